smplfir_decim: RTL and testbench

- Integrate-and-dump decimator placed directly downstream of the fixed [1,1] FIR stage.
- Consumes the FIR's clock-enabled output stream and sums each group of 2^LGDEC consecutive samples.
- Convergently rounds each sum to OW bits, saturating on overflow.
- Emits one result per group with a one-cycle output strobe that drives the next stage's clock-enable.

---
 rtl/smplfir_decim_convround.sv | 36 +++
 rtl/smplfir_decim.sv | 71 +++++++
 tb/tb_smplfir_decim.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/smplfir_decim_convround.sv
// Round-half-to-even from IW down to OW bits with positive saturation.
// Purely combinational; the parent registers the result.
module smplfir_decim_convround #(
    parameter int unsigned IW = 17,
    parameter int unsigned OW = 16
) (
    input  logic [IW-1:0] i_val,
    output logic [OW-1:0] o_val_c
);

    localparam int unsigned D = IW - OW;

    generate
        if (D == 0) begin : g_pass
            assign o_val_c = i_val;
        end else begin : g_round
            localparam logic [IW:0]   HALF_M1 = (IW+1)'((64'd1 << (D - 1)) - 64'd1);
            localparam logic [OW-1:0] POS_MAX = {1'b0, {(OW-1){1'b1}}};

            logic [IW:0] rnd;
            logic [OW:0] q;

            // One extra bit of headroom so the rounding add cannot wrap before the clip.
            always_comb begin
                rnd = {i_val[IW-1], i_val} + HALF_M1 + (IW+1)'(i_val[D]);
                q   = (OW+1)'(rnd >> D);
                if (!q[OW] && q[OW-1]) begin
                    o_val_c = POS_MAX;
                end else begin
                    o_val_c = q[OW-1:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/smplfir_decim.sv
// Integrate-and-dump decimator: sums groups of 2^LGDEC samples, then
// rounds (half-to-even) and saturates each sum to OW bits.
module smplfir_decim #(
    parameter int unsigned IW    = 16,
    parameter int unsigned LGDEC = 1,
    parameter int unsigned OW    = 16
) (
    input  logic          i_clk,
    input  logic          i_areset_n,
    input  logic          i_ce,
    input  logic [IW-1:0] i_val,
    output logic          o_ce,
    output logic [OW-1:0] o_val
);

    localparam int unsigned AW   = IW + LGDEC;
    localparam int unsigned NDEC = 1 << LGDEC;

    logic [LGDEC-1:0] r_count;
    logic [AW-1:0]    r_acc;
    logic [AW-1:0]    r_sum;
    logic             r_dump;
    logic [AW-1:0]    val_ext;
    logic [OW-1:0]    rnd_c;

    assign val_ext = {{LGDEC{i_val[IW-1]}}, i_val};

    // Stage 1: accumulate; the last sample of a group dumps into r_sum.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_count <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_dump  <= 1'b0;
        end else if (i_ce) begin
            r_count <= r_count + LGDEC'(1);
            if (r_count == LGDEC'(NDEC - 1)) begin
                r_sum  <= r_acc + val_ext;
                r_acc  <= '0;
                r_dump <= 1'b1;
            end else begin
                r_acc  <= r_acc + val_ext;
                r_dump <= 1'b0;
            end
        end else begin
            r_dump <= 1'b0;
        end
    end

    smplfir_decim_convround #(
        .IW (AW),
        .OW (OW)
    ) u_convround (
        .i_val   (r_sum),
        .o_val_c (rnd_c)
    );

    // Stage 2: register the rounded sum and its strobe.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_ce  <= 1'b0;
            o_val <= '0;
        end else if (r_dump) begin
            o_ce  <= 1'b1;
            o_val <= rnd_c;
        end else begin
            o_ce  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_smplfir_decim.sv
// Directed bench for smplfir_decim: three configurations sharing clock and reset.
module tb_smplfir_decim;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ce;
    logic signed [15:0] val;
    logic               ce_l2;
    logic signed [15:0] val_l2;

    logic               def_ce, sat_ce, l2_ce;
    logic signed [15:0] def_val;
    logic signed [7:0]  sat_val;
    logic signed [15:0] l2_val;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // IW=16, LGDEC=1, OW=16
    smplfir_decim #(.IW(16), .LGDEC(1), .OW(16)) u_def (
        .i_clk(clk), .i_areset_n(rst_n), .i_ce(ce), .i_val(val),
        .o_ce(def_ce), .o_val(def_val)
    );

    // IW=16, LGDEC=1, OW=8 (saturating)
    smplfir_decim #(.IW(16), .LGDEC(1), .OW(8)) u_sat (
        .i_clk(clk), .i_areset_n(rst_n), .i_ce(ce), .i_val(val),
        .o_ce(sat_ce), .o_val(sat_val)
    );

    // IW=16, LGDEC=2, OW=16
    smplfir_decim #(.IW(16), .LGDEC(2), .OW(16)) u_l2 (
        .i_clk(clk), .i_areset_n(rst_n), .i_ce(ce_l2), .i_val(val_l2),
        .o_ce(l2_ce), .o_val(l2_val)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated LGDEC=1 group, checked on both the 16-bit and 8-bit outputs.
    task automatic run_pair(input int a, input int b, input int exp_def, input int exp_sat);
        ce  = 1'b1;
        val = 16'(a);
        tick();
        val = 16'(b);
        tick();
        ce = 1'b0;
        check("pair_early_ce", int'(def_ce), 0);
        tick();
        check("pair_ce", int'(def_ce), 1);
        check("pair_val", int'(def_val), exp_def);
        check("pair_sat_ce", int'(sat_ce), 1);
        check("pair_sat_val", int'(sat_val), exp_sat);
        tick();
        check("pair_ce_drop", int'(def_ce), 0);
        check("pair_val_hold", int'(def_val), exp_def);
    endtask

    task automatic feed_l2(input int v, input int n);
        ce_l2  = 1'b1;
        val_l2 = 16'(v);
        for (int i = 0; i < n; i++) tick();
        ce_l2 = 1'b0;
    endtask

    int b2b_in  [8] = '{1, 1, 2, 2, -1, -1, 0, 0};
    int b2b_ce  [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
    int b2b_val [8] = '{0, 0, 1, 0, 2, 0, -1, 0};

    initial begin
        rst_n  = 1'b0;
        ce     = 1'b0;
        val    = '0;
        ce_l2  = 1'b0;
        val_l2 = '0;
        #12;
        check("rst_def_ce", int'(def_ce), 0);
        check("rst_def_val", int'(def_val), 0);
        check("rst_l2_ce", int'(l2_ce), 0);
        check("rst_sat_val", int'(sat_val), 0);
        rst_n = 1'b1;
        tick();

        run_pair(3, 4, 4, 0);
        run_pair(2, 3, 2, 0);
        run_pair(-3, -4, -4, 0);
        run_pair(32767, 32767, 32767, 127);
        run_pair(-32768, -32768, -32768, -128);

        // Back-to-back groups with continuous strobe.
        for (int i = 0; i < 8; i++) begin
            ce  = (i < 6);
            val = 16'(b2b_in[i]);
            tick();
            check("b2b_ce", int'(def_ce), b2b_ce[i]);
            if (b2b_ce[i] == 1) check("b2b_val", int'(def_val), b2b_val[i]);
        end
        ce = 1'b0;

        // Sparse strobe, LGDEC=2: ce one cycle in three.
        for (int i = 0; i < 16; i++) begin
            ce_l2  = (i % 3 == 0) && (i < 12);
            val_l2 = 16'sd1;
            tick();
            check("sparse_ce", int'(l2_ce), (i == 10) ? 1 : 0);
            check("sparse_val", int'(l2_val), (i >= 10) ? 1 : 0);
        end
        ce_l2 = 1'b0;

        // Reset mid-group discards the partial sum.
        feed_l2(100, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ce", int'(l2_ce), 0);
        check("midrst_val", int'(l2_val), 0);
        check("midrst_def_val", int'(def_val), 0);
        #2;
        rst_n = 1'b1;
        tick();
        feed_l2(4, 4);
        check("postrst_early", int'(l2_ce), 0);
        tick();
        check("postrst_ce", int'(l2_ce), 1);
        check("postrst_val", int'(l2_val), 4);
        tick();
        check("postrst_drop", int'(l2_ce), 0);

        // Reset while r_dump is high drops that result.
        feed_l2(8, 4);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("dumprst_ce", int'(l2_ce), 0);
        check("dumprst_val", int'(l2_val), 0);
        tick();
        check("dumprst_ce2", int'(l2_ce), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
